// File: rtl/fpu_pkg.sv
// Shared float32 definitions used by the FPU integer/float converters.
package fpu_pkg;

  localparam int unsigned FLOAT_EXP_W = 8;
  localparam int unsigned FLOAT_MAN_W = 23;
  localparam int unsigned FLOAT_BIAS  = 127;

  typedef struct packed {
    logic                   s;
    logic [FLOAT_EXP_W-1:0] e;
    logic [FLOAT_MAN_W-1:0] m;
  } float32_t;

endpackage

// File: rtl/lzc_n.sv
// Combinational leading-zero count; all-zero input yields W.
module lzc_n #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]       a,
  output logic [$clog2(W):0] cnt
);

  localparam int unsigned CW = $clog2(W) + 1;

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    cnt = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (a[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage integer-to-float32 converter with round-to-nearest-even and a
// global stall enable shared by every stage.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned INT_W = 32,
  parameter int unsigned EXP_W = FLOAT_EXP_W,
  parameter int unsigned MAN_W = FLOAT_MAN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_inexact
);

  localparam int unsigned ZW    = $clog2(INT_W) + 1;
  localparam int unsigned EXT_W = INT_W + MAN_W + 1;

  logic adv;

  logic             v1_q, s1_q;
  logic [INT_W-1:0] mag1_q;
  logic             s1_d;
  logic [INT_W-1:0] mag1_d;

  logic             v2_q, s2_q;
  logic [INT_W-1:0] norm2_q;
  logic [EXP_W-1:0] e2_q;
  logic [ZW-1:0]    lz;
  logic [INT_W-1:0] norm2_d;
  logic [EXP_W-1:0] e2_d;

  logic             v3_q, inexact_q;
  float32_t         res_q;
  float32_t         res_d;
  logic             inexact_d;

  logic [EXT_W-1:0] ext;
  logic [MAN_W-1:0] frac, frac_r;
  logic             g, st, up, carry;

  assign adv         = !v3_q || out_ready;
  assign in_ready    = adv;
  assign out_valid   = v3_q;
  assign out_data    = res_q;
  assign out_inexact = inexact_q;

  always_comb begin
    s1_d   = in_signed & in_data[INT_W-1];
    mag1_d = s1_d ? -in_data : in_data;
  end

  lzc_n #(
    .W(INT_W)
  ) u_lzc (
    .a  (mag1_q),
    .cnt(lz)
  );

  always_comb begin
    norm2_d = mag1_q << lz;
    e2_d    = EXP_W'(FLOAT_BIAS + INT_W - 1) - EXP_W'(lz);
  end

  // Bits below the hidden one, padded so guard/sticky always exist.
  always_comb begin
    ext   = {norm2_q[INT_W-2:0], {(MAN_W + 2){1'b0}}};
    frac  = ext[EXT_W-1 -: MAN_W];
    g     = ext[EXT_W-1-MAN_W];
    st    = |ext[EXT_W-2-MAN_W:0];
    up    = g & (st | frac[0]);
    {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, up};
    res_d.s   = s2_q;
    res_d.e   = e2_q + EXP_W'(carry);
    res_d.m   = frac_r;
    inexact_d = g | st;
    if (!norm2_q[INT_W-1]) begin
      res_d     = '0;
      inexact_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1_q      <= 1'b0;
      s1_q      <= 1'b0;
      mag1_q    <= '0;
      v2_q      <= 1'b0;
      s2_q      <= 1'b0;
      norm2_q   <= '0;
      e2_q      <= '0;
      v3_q      <= 1'b0;
      res_q     <= '0;
      inexact_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      if (in_valid) begin
        s1_q   <= s1_d;
        mag1_q <= mag1_d;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        s2_q    <= s1_q;
        norm2_q <= norm2_d;
        e2_q    <= e2_d;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        res_q     <= res_d;
        inexact_q <= inexact_d;
      end
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// Scoreboard bench for itof_pipe at INT_W=32, plus INT_W=16/64 instances checked
// against an arithmetic reference model.
module tb_itof_pipe;

  logic clk, rstn;

  logic        iv, ir, isg, ov, ordy, ox;
  logic [31:0] id, od;

  logic        iv16, ir16, isg16, ov16, ox16;
  logic [15:0] id16;
  logic [31:0] od16;

  logic        iv64, ir64, isg64, ov64, ox64;
  logic [63:0] id64;
  logic [31:0] od64;

  typedef struct {
    logic [32:0] v;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        q32[$];
  logic [32:0] q16[$];
  logic [32:0] q64[$];
  exp_t        e32;
  logic [32:0] held;
  bit          stalled = 0;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  logic [31:0] bp_exp [10] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                               32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
                               32'h4110_0000, 32'h4120_0000};

  itof_pipe #(.INT_W(32)) u_dut32 (
    .clk(clk), .rstn(rstn), .in_valid(iv), .in_ready(ir), .in_data(id), .in_signed(isg),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_inexact(ox)
  );

  itof_pipe #(.INT_W(16)) u_dut16 (
    .clk(clk), .rstn(rstn), .in_valid(iv16), .in_ready(ir16), .in_data(id16),
    .in_signed(isg16), .out_valid(ov16), .out_ready(1'b1), .out_data(od16),
    .out_inexact(ox16)
  );

  itof_pipe #(.INT_W(64)) u_dut64 (
    .clk(clk), .rstn(rstn), .in_valid(iv64), .in_ready(ir64), .in_data(id64),
    .in_signed(isg64), .out_valid(ov64), .out_ready(1'b1), .out_data(od64),
    .out_inexact(ox64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Independent model: find MSB, shift right, compare discarded remainder to half.
  function automatic logic [32:0] ref_cvt(input logic [63:0] v_in, input int w, input bit sgn);
    logic [63:0] mask, v, mag, q, rem, half;
    bit s;
    int p, sh;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    v    = v_in & mask;
    s    = sgn && v[w-1];
    mag  = s ? ((~v + 64'd1) & mask) : v;
    if (mag == 64'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    rem = 64'd0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[24]) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    return {rem != 64'd0, s, 8'(127 + p), q[22:0]};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the operand is accepted.
  task automatic send(input logic [31:0] d, input bit sg, input logic [32:0] ev, input bit lat);
    int n = 0;
    exp_t e;
    iv  = 1'b1;
    id  = d;
    isg = sg;
    forever begin
      @(negedge clk);
      if (ir) break;
      n++;
      if (n > 50) begin
        total++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, operand %h", n, d);
        iv = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    e.v   = ev;
    e.acc = cyc;
    e.lat = lat;
    q32.push_back(e);
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0 || q64.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q32.size() != 0 || q16.size() != 0 || q64.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: pending %0d/%0d/%0d", q32.size(), q16.size(), q64.size());
      q32.delete();
      q16.delete();
      q64.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (ov && ordy) begin
        stalled = 0;
        if (q32.size() == 0) begin
          total++;
          $display("FAIL out32_unexpected: got %h expected none", {ox, od});
        end else begin
          e32 = q32.pop_front();
          chk("out32", {31'd0, ox, od}, {31'd0, e32.v});
          if (e32.lat) chk("latency32", 64'(cyc - e32.acc), 64'd3);
        end
      end else if (ov && !ordy) begin
        chk("stall_in_ready", {63'd0, ir}, 64'd0);
        if (stalled) chk("stall_hold", {31'd0, ox, od}, {31'd0, held});
        held    = {ox, od};
        stalled = 1;
      end else begin
        stalled = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && ov16) begin
      if (q16.size() == 0) begin
        total++;
        $display("FAIL out16_unexpected: got %h expected none", {ox16, od16});
      end else chk("out16", {31'd0, ox16, od16}, {31'd0, q16.pop_front()});
    end
    if (rstn && ov64) begin
      if (q64.size() == 0) begin
        total++;
        $display("FAIL out64_unexpected: got %h expected none", {ox64, od64});
      end else chk("out64", {31'd0, ox64, od64}, {31'd0, q64.pop_front()});
    end
  end

  initial begin
    logic [63:0] r64;
    logic [15:0] d16;
    logic [63:0] d64;
    bit          sg16, sg64;

    rstn = 1'b0; ordy = 1'b1;
    iv = 1'b0; id = '0; isg = 1'b0;
    iv16 = 1'b0; id16 = '0; isg16 = 1'b0;
    iv64 = 1'b0; id64 = '0; isg64 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", {63'd0, ov}, 64'd0);
    chk("rst_out_data", {32'd0, od}, 64'd0);
    chk("rst_out_inexact", {63'd0, ox}, 64'd0);
    chk("rst_in_ready", {63'd0, ir}, 64'd1);
    @(posedge clk); #1;

    send(32'h0000_0001, 1'b1, {1'b0, 32'h3F80_0000}, 1'b1); drain();
    send(32'hFFFF_FFFF, 1'b1, {1'b0, 32'hBF80_0000}, 1'b1); drain();
    send(32'h0000_0000, 1'b1, {1'b0, 32'h0000_0000}, 1'b1); drain();

    // Back to back without stalls: every result still exactly 3 cycles behind.
    send(32'h0100_0001, 1'b1, {1'b1, 32'h4B80_0000}, 1'b1);
    send(32'h0100_0003, 1'b1, {1'b1, 32'h4B80_0002}, 1'b1);
    send(32'h7FFF_FFFF, 1'b1, {1'b1, 32'h4F00_0000}, 1'b1);
    send(32'h8000_0000, 1'b1, {1'b0, 32'hCF00_0000}, 1'b1);
    send(32'hFFFF_FFFF, 1'b0, {1'b1, 32'h4F80_0000}, 1'b1);
    send(32'h8000_0000, 1'b0, {1'b0, 32'h4F00_0000}, 1'b1);
    drain();

    fork
      begin
        for (int i = 0; i < 10; i++) send(32'(i + 1), 1'b0, {1'b0, bp_exp[i]}, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 ordy = 1'b0;
        repeat (5) @(posedge clk);
        #1 ordy = 1'b1;
      end
    join
    drain();
    chk("bp_queue_empty", 64'(q32.size()), 64'd0);

    send(32'd2, 1'b0, {1'b0, 32'h4000_0000}, 1'b0);
    send(32'd3, 1'b0, {1'b0, 32'h4040_0000}, 1'b0);
    send(32'd4, 1'b0, {1'b0, 32'h4080_0000}, 1'b0);
    rstn = 1'b0;
    q32.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_out_valid", {63'd0, ov}, 64'd0);
      if (k == 0) chk("midrst_in_ready", {63'd0, ir}, 64'd1);
      @(posedge clk); #1;
    end
    send(32'h0000_0001, 1'b1, {1'b0, 32'h3F80_0000}, 1'b1);
    drain();

    for (int i = 0; i < 24; i++) begin
      r64  = {$urandom, $urandom};
      d64  = r64 >> $urandom_range(0, 63);
      sg64 = 1'($urandom);
      if (i == 0) begin
        d16  = 16'h8000;
        sg16 = 1'b1;
        q16.push_back({1'b0, 32'hC700_0000});
      end else begin
        d16  = 16'($urandom >> $urandom_range(0, 31));
        sg16 = 1'($urandom);
        q16.push_back(ref_cvt({48'd0, d16}, 16, sg16));
      end
      if (i == 1) begin
        d64  = 64'h8000_0000_0000_0000;
        sg64 = 1'b1;
      end
      q64.push_back(ref_cvt(d64, 64, sg64));
      iv16 = 1'b1; id16 = d16; isg16 = sg16;
      iv64 = 1'b1; id64 = d64; isg64 = sg64;
      @(negedge clk);
      chk("sweep_in_ready", {62'd0, ir16, ir64}, 64'd3);
      @(posedge clk); #1;
    end
    iv16 = 1'b0;
    iv64 = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
